// File: rtl/fpdiv_share_arb_if.sv
// Signal bundle between the shared-divider arbiter, its requesters, the divider and the result sink.
// master: the arbiter side. slave: the environment side (requesters, divider, downstream).
// Widths follow NREQ/W; TAGW is derived the same way as inside the arbiter.
interface fpdiv_share_arb_if #(
  parameter int NREQ = 2,
  parameter int W    = 34,
  parameter int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [W-1:0]      div_x;
  logic [W-1:0]      div_y;
  logic              div_stall;
  logic [W-1:0]      div_r;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [TAGW-1:0]   out_tag;
  logic [31:0]       stat_issued;
  logic [31:0]       stat_stalls;

  modport master (
    input  req_valid, req_x, req_y, div_r, out_ready,
    output req_ready, div_x, div_y, div_stall, out_valid, out_data, out_tag,
           stat_issued, stat_stalls
  );

  modport slave (
    output req_valid, req_x, req_y, div_r, out_ready,
    input  req_ready, div_x, div_y, div_stall, out_valid, out_data, out_tag,
           stat_issued, stat_stalls
  );
endinterface

// File: rtl/fpdiv_share_arb.sv
// Round-robin time-sharing of one stall-able pipelined FP divider among NREQ requesters, tagged result stream.
// Latency: LAT enabled cycles from accept edge to result (operand register included); 1 issue/cycle peak.
// Backpressure: a blocked valid result freezes the tracker and the divider (div_stall) and blocks all issue.
// Optional statistics counters are built only when FPDIV_ARB_STATS_EN is defined; otherwise the stat ports read 0.
module fpdiv_share_arb #(
  parameter int NREQ = 2,
  parameter int W    = 34,
  parameter int LAT  = 13
) (
  input  logic              clk,
  input  logic              rst,
  fpdiv_share_arb_if.master bus
);
  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LAT-1:0]           vld;
  logic [LAT-1:0][TAGW-1:0] tag;
  logic [TAGW-1:0]          ptr;
  logic [W-1:0]             x_q;
  logic [W-1:0]             y_q;

  logic            hi_found, lo_found;
  logic [TAGW-1:0] hi_idx, lo_idx, gnt_idx;
  logic            any_cand;
  logic            out_vld_int;
  logic            stall;
  logic            adv;
  logic            issue;
  logic [NREQ-1:0] rdy;

  // Round-robin pick: lowest valid index above ptr wins, else lowest valid index at or below ptr (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = TAGW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = TAGW'(i);
        end
      end
    end
    any_cand = hi_found | lo_found;
    gnt_idx  = hi_found ? hi_idx : lo_idx;
  end

  // Results are masked while rst is high so nothing is handed out or accepted during reset.
  assign out_vld_int = vld[LAT-1] & ~rst;
  assign stall       = out_vld_int & ~bus.out_ready;
  assign adv         = ~stall;
  assign issue       = adv & any_cand & ~rst;

  // Accept strobe: one-hot on the granted requester, only when the issue actually happens.
  always_comb begin
    rdy = '0;
    if (issue) rdy[gnt_idx] = 1'b1;
  end

  // Tracker shifts in lock-step with the divider; operand register and pointer load only on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
      ptr <= TAGW'(NREQ - 1);
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (adv) begin
        vld <= {vld[LAT-2:0], issue};
        tag <= {tag[LAT-2:0], gnt_idx};
      end
      if (issue) begin
        x_q <= bus.req_x[int'(gnt_idx)*W +: W];
        y_q <= bus.req_y[int'(gnt_idx)*W +: W];
        ptr <= gnt_idx;
      end
    end
  end

  assign bus.req_ready = rdy;
  assign bus.div_x     = x_q;
  assign bus.div_y     = y_q;
  assign bus.div_stall = stall;
  assign bus.out_valid = out_vld_int;
  assign bus.out_data  = bus.div_r;
  assign bus.out_tag   = tag[LAT-1];

`ifdef FPDIV_ARB_STATS_EN
  logic [31:0] n_issued;
  logic [31:0] n_stalls;

  // Free-running wrap-around event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_issued <= '0;
      n_stalls <= '0;
    end else begin
      if (issue) n_issued <= n_issued + 32'd1;
      if (stall) n_stalls <= n_stalls + 32'd1;
    end
  end

  assign bus.stat_issued = n_issued;
  assign bus.stat_stalls = n_stalls;
`else
  assign bus.stat_issued = '0;
  assign bus.stat_stalls = '0;
`endif
endmodule
